// File: rtl/writeback_stage_if.sv
// Bundle, data-memory and retire signals of the writeback stage.
// The slave modport is the stage; the master modport is the surrounding pipeline/memory.
interface writeback_stage_if #(
  parameter int XLEN = 64
);
  logic            WB_V;
  logic [31:0]     WB_IR;
  logic [XLEN-1:0] WB_NPC;
  logic [XLEN-1:0] WB_ALU_RESULT;
  logic [XLEN-1:0] WB_SR2;
  logic [XLEN-1:0] WB_CSRFD;
  logic            WB_PC_MUX;
  logic            WB_ECALL;
  logic            WB_STALL;
  logic            DMEM_REQ;
  logic            DMEM_WE;
  logic [XLEN-1:0] DMEM_ADDR;
  logic [XLEN-1:0] DMEM_WDATA;
  logic [7:0]      DMEM_WSTRB;
  logic            DMEM_ACK;
  logic [XLEN-1:0] DMEM_RDATA;
  logic            RF_WE;
  logic [4:0]      RF_WADDR;
  logic [XLEN-1:0] RF_WDATA;
  logic            PC_REDIRECT;
  logic [XLEN-1:0] PC_TARGET;
  logic            ECALL_OUT;
  logic            WB_LAF;
  logic            RETIRE;

  modport slave (
    input  WB_V, WB_IR, WB_NPC, WB_ALU_RESULT, WB_SR2, WB_CSRFD, WB_PC_MUX, WB_ECALL,
    input  DMEM_ACK, DMEM_RDATA,
    output WB_STALL, DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB,
    output RF_WE, RF_WADDR, RF_WDATA, PC_REDIRECT, PC_TARGET, ECALL_OUT, WB_LAF, RETIRE
  );

  modport master (
    output WB_V, WB_IR, WB_NPC, WB_ALU_RESULT, WB_SR2, WB_CSRFD, WB_PC_MUX, WB_ECALL,
    output DMEM_ACK, DMEM_RDATA,
    input  WB_STALL, DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB,
    input  RF_WE, RF_WADDR, RF_WDATA, PC_REDIRECT, PC_TARGET, ECALL_OUT, WB_LAF, RETIRE
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: data-memory access, load extraction and retire strobes.
// Optional access timeout enabled by defining DMEM_TIMEOUT_EN.
module writeback_stage #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  writeback_stage_if.slave  bus
);
  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_SYSTEM = 7'b1110011;

  state_t          r_state, w_state_next;
  logic [14:0]     r_ir;
  logic [XLEN-1:0] r_npc, r_alu, r_sr2, r_csrfd;
  logic            r_pc_mux, r_ecall;

  logic            r_retire, r_rf_we, r_pc_redirect, r_ecall_out, r_laf;
  logic [4:0]      r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata, r_pc_target;

  logic            w_access, w_accept, w_in_mem, w_ack, w_timeout, w_retire;
  logic [14:0]     w_ir;
  logic [XLEN-1:0] w_npc, w_alu, w_csrfd;
  logic            w_pc_mux, w_ecall;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rd;
  logic            w_writes_rd, w_rf_we;
  logic [XLEN-1:0] w_lane, w_load_data, w_rf_wdata;
  logic [7:0]      w_wstrb;
  logic [5:0]      w_shamt;
  logic            w_unused;

  assign w_access = (r_state == S_ACCESS);
  assign w_accept = (r_state == S_IDLE) && bus.WB_V;
  assign w_in_mem = (bus.WB_IR[6:0] == OP_LOAD) || (bus.WB_IR[6:0] == OP_STORE);
  assign w_ack    = w_access && bus.DMEM_ACK;

  // While idle, a non-memory instruction retires straight from the incoming bundle.
  assign w_ir     = w_access ? r_ir     : bus.WB_IR[14:0];
  assign w_npc    = w_access ? r_npc    : bus.WB_NPC;
  assign w_alu    = w_access ? r_alu    : bus.WB_ALU_RESULT;
  assign w_csrfd  = w_access ? r_csrfd  : bus.WB_CSRFD;
  assign w_pc_mux = w_access ? r_pc_mux : bus.WB_PC_MUX;
  assign w_ecall  = w_access ? r_ecall  : bus.WB_ECALL;
  assign w_opcode = w_ir[6:0];
  assign w_rd     = w_ir[11:7];
  assign w_funct3 = w_ir[14:12];

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  assign w_timeout = w_access && !bus.DMEM_ACK && (r_tmo_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if (w_access && !bus.DMEM_ACK) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_retire = (w_accept && !w_in_mem) || w_ack || w_timeout;
  assign w_shamt  = {r_alu[2:0], 3'b000};
  assign w_lane   = bus.DMEM_RDATA >> w_shamt;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && w_in_mem) w_state_next = S_ACCESS;
      S_ACCESS: if (w_ack || w_timeout) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load_data = w_lane;
    case (r_ir[14:12])
      3'b000:  w_load_data = {{(XLEN-8){w_lane[7]}},   w_lane[7:0]};
      3'b001:  w_load_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load_data = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}},        w_lane[7:0]};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}},       w_lane[15:0]};
      3'b110:  w_load_data = {{(XLEN-32){1'b0}},       w_lane[31:0]};
      default: w_load_data = w_lane;
    endcase
  end

  always_comb begin
    w_wstrb = 8'h00;
    if (r_ir[6:0] == OP_STORE) begin
      case (r_ir[13:12])
        2'b00:   w_wstrb = 8'h01 << r_alu[2:0];
        2'b01:   w_wstrb = 8'h03 << r_alu[2:0];
        2'b10:   w_wstrb = 8'h0F << r_alu[2:0];
        default: w_wstrb = 8'hFF;
      endcase
    end
  end

  always_comb begin
    w_writes_rd = 1'b0;
    case (w_opcode)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, OP_LOAD: w_writes_rd = 1'b1;
      OP_SYSTEM: w_writes_rd = (w_funct3 != 3'b000);
      default:   w_writes_rd = 1'b0;
    endcase
    w_rf_we = w_writes_rd && (w_rd != 5'd0) && !w_timeout && !w_ecall;
    // Jumps carry PC+4 in ALU_RESULT, so they share the default path.
    if (w_opcode == OP_SYSTEM)    w_rf_wdata = w_csrfd;
    else if (w_opcode == OP_LOAD) w_rf_wdata = w_load_data;
    else                          w_rf_wdata = w_alu;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_ir          <= '0;
      r_npc         <= '0;
      r_alu         <= '0;
      r_sr2         <= '0;
      r_csrfd       <= '0;
      r_pc_mux      <= 1'b0;
      r_ecall       <= 1'b0;
      r_retire      <= 1'b0;
      r_rf_we       <= 1'b0;
      r_rf_waddr    <= '0;
      r_rf_wdata    <= '0;
      r_pc_redirect <= 1'b0;
      r_pc_target   <= '0;
      r_ecall_out   <= 1'b0;
      r_laf         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_ir     <= bus.WB_IR[14:0];
        r_npc    <= bus.WB_NPC;
        r_alu    <= bus.WB_ALU_RESULT;
        r_sr2    <= bus.WB_SR2;
        r_csrfd  <= bus.WB_CSRFD;
        r_pc_mux <= bus.WB_PC_MUX;
        r_ecall  <= bus.WB_ECALL;
      end
      r_retire      <= w_retire;
      r_rf_we       <= w_retire && w_rf_we;
      r_pc_redirect <= w_retire && w_pc_mux;
      r_ecall_out   <= w_retire && w_ecall;
      r_laf         <= w_timeout;
      if (w_retire && w_rf_we) begin
        r_rf_waddr <= w_rd;
        r_rf_wdata <= w_rf_wdata;
      end
      if (w_retire && w_pc_mux) r_pc_target <= w_npc;
    end
  end

  assign bus.WB_STALL    = w_access;
  assign bus.DMEM_REQ    = w_access;
  assign bus.DMEM_WE     = w_access && (r_ir[6:0] == OP_STORE);
  assign bus.DMEM_ADDR   = {r_alu[XLEN-1:3], 3'b000};
  assign bus.DMEM_WDATA  = r_sr2 << w_shamt;
  assign bus.DMEM_WSTRB  = w_access ? w_wstrb : 8'h00;
  assign bus.RF_WE       = r_rf_we;
  assign bus.RF_WADDR    = r_rf_waddr;
  assign bus.RF_WDATA    = r_rf_wdata;
  assign bus.PC_REDIRECT = r_pc_redirect;
  assign bus.PC_TARGET   = r_pc_target;
  assign bus.ECALL_OUT   = r_ecall_out;
  assign bus.WB_LAF      = r_laf;
  assign bus.RETIRE      = r_retire;

  assign w_unused = &{1'b0, bus.WB_IR[31:15], (MEM_TIMEOUT != 0)};
endmodule

// File: tb/tb_writeback_stage.sv
// Directed test of writeback_stage: ALU retire, loads, stores, redirects, reset, optional timeout.
module tb_writeback_stage;
`ifdef DMEM_TIMEOUT_EN
  localparam int TB_TMO = 4;
`else
  localparam int TB_TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  writeback_stage_if #(.XLEN(64)) bus ();

  writeback_stage #(.XLEN(64), .MEM_TIMEOUT(TB_TMO)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.WB_V = 1'b0; bus.WB_IR = 32'h0; bus.WB_NPC = '0; bus.WB_ALU_RESULT = '0;
    bus.WB_SR2 = '0; bus.WB_CSRFD = '0; bus.WB_PC_MUX = 1'b0; bus.WB_ECALL = 1'b0;
    bus.DMEM_ACK = 1'b0; bus.DMEM_RDATA = '0;
  endtask

  task automatic drive_bundle(input logic [31:0] ir, input logic [63:0] alu,
                              input logic [63:0] npc, input logic pc_mux);
    bus.WB_V = 1'b1; bus.WB_IR = ir; bus.WB_ALU_RESULT = alu;
    bus.WB_NPC = npc; bus.WB_PC_MUX = pc_mux; bus.WB_ECALL = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    total++; if ({bus.RETIRE, bus.RF_WE, bus.DMEM_REQ, bus.WB_STALL, bus.WB_LAF} !== 5'b0)
      $display("FAIL reset_strobes got %b exp 00000", {bus.RETIRE, bus.RF_WE, bus.DMEM_REQ, bus.WB_STALL, bus.WB_LAF}); else passed++;
    total++; if ({bus.RF_WDATA, bus.PC_TARGET, bus.DMEM_WSTRB} !== '0)
      $display("FAIL reset_data got %h %h %h exp 0", bus.RF_WDATA, bus.PC_TARGET, bus.DMEM_WSTRB); else passed++;
    rst = 1'b0;
    bus.DMEM_ACK = 1'b1;
    tick();
    bus.DMEM_ACK = 1'b0;
    total++; if (bus.RETIRE !== 1'b0) $display("FAIL idle_ack_ignored got %b exp 0", bus.RETIRE); else passed++;
    $display("txn reset done");
  endtask

  task automatic test_alu();
    drive_bundle(32'h02A00293, 64'h2A, 64'h104, 1'b0);
    tick();
    drive_idle();
    total++; if ({bus.RF_WE, bus.RETIRE, bus.WB_STALL} !== 3'b110)
      $display("FAIL addi_strobes got %b exp 110", {bus.RF_WE, bus.RETIRE, bus.WB_STALL}); else passed++;
    total++; if (bus.RF_WADDR !== 5'd5) $display("FAIL addi_waddr got %0d exp 5", bus.RF_WADDR); else passed++;
    total++; if (bus.RF_WDATA !== 64'h2A) $display("FAIL addi_wdata got %h exp 2a", bus.RF_WDATA); else passed++;
    tick();
    total++; if ({bus.RF_WE, bus.RETIRE} !== 2'b00)
      $display("FAIL addi_one_pulse got %b exp 00", {bus.RF_WE, bus.RETIRE}); else passed++;
    total++; if (bus.RF_WDATA !== 64'h2A) $display("FAIL addi_hold got %h exp 2a", bus.RF_WDATA); else passed++;
    $display("txn addi x5 rd=%0d data=%h", bus.RF_WADDR, bus.RF_WDATA);
  endtask

  task automatic test_load();
    logic [31:0] irs   [3] = '{32'h00000303, 32'h00004303, 32'h00002303};
    logic [63:0] addrs [3] = '{64'h1003, 64'h1003, 64'h1004};
    logic [63:0] rdats [3] = '{64'h00000000_80000000, 64'h00000000_80000000, 64'h80000000_12345678};
    logic [63:0] exps  [3] = '{64'hFFFFFFFF_FFFFFF80, 64'h80, 64'hFFFFFFFF_80000000};
    int          lats  [3] = '{3, 1, 1};
    int          stalls;
    for (int t = 0; t < 3; t++) begin
      drive_bundle(irs[t], addrs[t], 64'h0, 1'b0);
      tick();
      drive_idle();
      total++; if ({bus.DMEM_REQ, bus.DMEM_WE, bus.DMEM_WSTRB} !== {2'b10, 8'h00})
        $display("FAIL load%0d_req got %b %b %h exp 1 0 00", t, bus.DMEM_REQ, bus.DMEM_WE, bus.DMEM_WSTRB); else passed++;
      total++; if (bus.DMEM_ADDR !== {addrs[t][63:3], 3'b000})
        $display("FAIL load%0d_addr got %h exp %h", t, bus.DMEM_ADDR, {addrs[t][63:3], 3'b000}); else passed++;
      stalls = 0;
      for (int c = 0; c < lats[t]; c++) begin
        if (bus.WB_STALL === 1'b1) stalls++;
        if (c == lats[t] - 1) begin
          bus.DMEM_ACK = 1'b1;
          bus.DMEM_RDATA = rdats[t];
        end
        tick();
      end
      drive_idle();
      total++; if (stalls !== lats[t] || bus.WB_STALL !== 1'b0)
        $display("FAIL load%0d_stall got %0d cycles then %b exp %0d then 0", t, stalls, bus.WB_STALL, lats[t]); else passed++;
      total++; if ({bus.RETIRE, bus.RF_WE, bus.DMEM_REQ} !== 3'b110)
        $display("FAIL load%0d_retire got %b exp 110", t, {bus.RETIRE, bus.RF_WE, bus.DMEM_REQ}); else passed++;
      total++; if (bus.RF_WDATA !== exps[t] || bus.RF_WADDR !== 5'd6)
        $display("FAIL load%0d_data got %h rd %0d exp %h rd 6", t, bus.RF_WDATA, bus.RF_WADDR, exps[t]); else passed++;
      $display("txn load%0d addr=%h data=%h", t, addrs[t], bus.RF_WDATA);
      tick();
    end
  endtask

  task automatic test_store();
    drive_bundle(32'h00001023, 64'h2006, 64'h0, 1'b0);
    bus.WB_SR2 = 64'hBEEF;
    tick();
    drive_idle();
    total++; if ({bus.DMEM_REQ, bus.DMEM_WE, bus.DMEM_WSTRB} !== {2'b11, 8'hC0})
      $display("FAIL sh_req got %b %b %h exp 1 1 c0", bus.DMEM_REQ, bus.DMEM_WE, bus.DMEM_WSTRB); else passed++;
    total++; if (bus.DMEM_WDATA !== 64'hBEEF0000_00000000 || bus.DMEM_ADDR !== 64'h2000)
      $display("FAIL sh_bus got %h @%h exp beef000000000000 @2000", bus.DMEM_WDATA, bus.DMEM_ADDR); else passed++;
    bus.DMEM_ACK = 1'b1;
    tick();
    drive_idle();
    total++; if ({bus.RETIRE, bus.RF_WE, bus.DMEM_REQ} !== 3'b100)
      $display("FAIL sh_retire got %b exp 100", {bus.RETIRE, bus.RF_WE, bus.DMEM_REQ}); else passed++;
    total++; if (bus.RF_WADDR !== 5'd6) $display("FAIL sh_waddr_hold got %0d exp 6", bus.RF_WADDR); else passed++;
    $display("txn sh addr=2006");
    tick();
  endtask

  task automatic test_branch();
    drive_bundle(32'h00000063, 64'h0, 64'h400, 1'b1);
    tick();
    drive_bundle(32'h00100013, 64'h1, 64'h0, 1'b0);
    total++; if ({bus.PC_REDIRECT, bus.RETIRE, bus.RF_WE} !== 3'b110 || bus.PC_TARGET !== 64'h400)
      $display("FAIL beq got %b tgt %h exp 110 tgt 400", {bus.PC_REDIRECT, bus.RETIRE, bus.RF_WE}, bus.PC_TARGET); else passed++;
    tick();
    drive_idle();
    total++; if ({bus.PC_REDIRECT, bus.RETIRE, bus.RF_WE} !== 3'b010)
      $display("FAIL addi_x0 got %b exp 010", {bus.PC_REDIRECT, bus.RETIRE, bus.RF_WE}); else passed++;
    $display("txn beq target=%h then addi x0", bus.PC_TARGET);
    tick();
  endtask

  task automatic test_back_to_back();
    drive_bundle(32'h000000EF, 64'h104, 64'h800, 1'b1);
    tick();
    drive_bundle(32'h000023F3, 64'h999, 64'h0, 1'b0);
    bus.WB_CSRFD = 64'h55;
    total++; if ({bus.RF_WE, bus.PC_REDIRECT} !== 2'b11 || bus.RF_WDATA !== 64'h104 || bus.RF_WADDR !== 5'd1 || bus.PC_TARGET !== 64'h800)
      $display("FAIL jal got %b %h rd %0d tgt %h exp 11 104 rd 1 tgt 800", {bus.RF_WE, bus.PC_REDIRECT}, bus.RF_WDATA, bus.RF_WADDR, bus.PC_TARGET); else passed++;
    tick();
    drive_bundle(32'h00000073, 64'h0, 64'h0, 1'b0);
    bus.WB_ECALL = 1'b1;
    total++; if ({bus.RF_WE, bus.RETIRE, bus.PC_REDIRECT} !== 3'b110 || bus.RF_WDATA !== 64'h55 || bus.RF_WADDR !== 5'd7)
      $display("FAIL csrrs got %b %h rd %0d exp 110 55 rd 7", {bus.RF_WE, bus.RETIRE, bus.PC_REDIRECT}, bus.RF_WDATA, bus.RF_WADDR); else passed++;
    tick();
    drive_idle();
    total++; if ({bus.ECALL_OUT, bus.RETIRE, bus.RF_WE} !== 3'b110)
      $display("FAIL ecall got %b exp 110", {bus.ECALL_OUT, bus.RETIRE, bus.RF_WE}); else passed++;
    $display("txn jal/csrrs/ecall back to back");
    tick();
  endtask

  task automatic test_reset_mid_access();
    drive_bundle(32'h00003383, 64'h3000, 64'h0, 1'b0);
    tick();
    drive_idle();
    total++; if ({bus.DMEM_REQ, bus.WB_STALL} !== 2'b11)
      $display("FAIL rst_pre got %b exp 11", {bus.DMEM_REQ, bus.WB_STALL}); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if ({bus.DMEM_REQ, bus.WB_STALL} !== 2'b00)
      $display("FAIL rst_async got %b exp 00", {bus.DMEM_REQ, bus.WB_STALL}); else passed++;
    bus.DMEM_ACK = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.DMEM_ACK = 1'b0;
    total++; if ({bus.RETIRE, bus.DMEM_REQ, bus.RF_WE} !== 3'b000)
      $display("FAIL rst_ack_ignored got %b exp 000", {bus.RETIRE, bus.DMEM_REQ, bus.RF_WE}); else passed++;
    $display("txn reset during access");
    tick();
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    int req_cycles = 0;
    drive_bundle(32'h00003383, 64'h3000, 64'h0, 1'b0);
    tick();
    drive_idle();
    while (bus.DMEM_REQ === 1'b1 && req_cycles < 10) begin
      req_cycles++;
      tick();
    end
    total++; if (req_cycles !== 4) $display("FAIL tmo_req_cycles got %0d exp 4", req_cycles); else passed++;
    total++; if ({bus.WB_LAF, bus.RETIRE, bus.RF_WE} !== 3'b110)
      $display("FAIL tmo_retire got %b exp 110", {bus.WB_LAF, bus.RETIRE, bus.RF_WE}); else passed++;
    bus.DMEM_ACK = 1'b1;
    tick();
    bus.DMEM_ACK = 1'b0;
    total++; if ({bus.WB_LAF, bus.RETIRE} !== 2'b00)
      $display("FAIL tmo_late_ack got %b exp 00", {bus.WB_LAF, bus.RETIRE}); else passed++;
    $display("txn timeout after %0d cycles", req_cycles);
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_reset_mid_access();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
